// File: rtl/dot_accum_if.sv
// Command/product bus into dot_accum and its accumulator/status outputs.
interface dot_accum_if #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 32
) ();
  logic                        stall;
  logic [1:0]                  dot_ctrl;
  logic [LANES*DATA_WIDTH-1:0] prod_in;
  logic [DATA_WIDTH-1:0]       dot_out;
  logic                        dot_valid;
  logic                        busy;
  logic                        sat_flag;

  modport master (
    output stall, dot_ctrl, prod_in,
    input  dot_out, dot_valid, busy, sat_flag
  );

  modport slave (
    input  stall, dot_ctrl, prod_in,
    output dot_out, dot_valid, busy, sat_flag
  );
endinterface

// File: rtl/dot_accum.sv
// Pipelined adder-tree dot-product accumulator: log2(LANES)+1 cycle latency, stall freezes every stage.
// Define DOT_ACCUM_SAT_EN for saturating adders and a sticky sat_flag; default build wraps.
module dot_accum #(
  parameter int LANES      = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  dot_accum_if.slave  bus
);
  localparam int STAGES = $clog2(LANES);
  localparam int NODES  = 2 * LANES;

  typedef logic [DATA_WIDTH-1:0] dat_t;

`ifdef DOT_ACCUM_SAT_EN
  localparam dat_t MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam dat_t MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic ovf_fn(input dat_t a, input dat_t b);
    dat_t s;
    s = a + b;
    return (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
  endfunction
`endif

  function automatic dat_t add_fn(input dat_t a, input dat_t b);
    dat_t s;
    s = a + b;
`ifdef DOT_ACCUM_SAT_EN
    if (ovf_fn(a, b)) s = a[DATA_WIDTH-1] ? MIN_VAL : MAX_VAL;
`endif
    return s;
  endfunction

  // Heap-ordered tree: node n sums children 2n and 2n+1; nodes LANES.. are the raw lanes.
  dat_t       tree_q [1:LANES-1];
  dat_t       tree_d [1:LANES-1];
  dat_t       node   [1:NODES-1];
  logic [1:0] ctrl_q [STAGES];
  dat_t       acc_q;
  logic       vld_q;
  logic       busy_c;

  always_comb begin
    for (int n = 1; n < LANES; n++) node[n] = tree_q[n];
    for (int i = 0; i < LANES; i++) node[LANES+i] = bus.prod_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    for (int n = 1; n < LANES; n++) tree_d[n] = add_fn(node[2*n], node[2*n+1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 1; n < LANES; n++) tree_q[n] <= '0;
      for (int k = 0; k < STAGES; k++) ctrl_q[k] <= 2'b00;
    end else if (!bus.stall) begin
      for (int n = 1; n < LANES; n++) tree_q[n] <= tree_d[n];
      ctrl_q[0] <= bus.dot_ctrl;
      for (int k = 1; k < STAGES; k++) ctrl_q[k] <= ctrl_q[k-1];
    end
  end

  // Accumulate stage consumes the root sum alongside the last ctrl register.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
      vld_q <= 1'b0;
    end else if (bus.stall) begin
      vld_q <= 1'b0;
    end else begin
      vld_q <= (ctrl_q[STAGES-1] != 2'b00);
      case (ctrl_q[STAGES-1])
        2'b01:   acc_q <= tree_q[1];
        2'b10:   acc_q <= add_fn(acc_q, tree_q[1]);
        2'b11:   acc_q <= '0;
        default: acc_q <= acc_q;
      endcase
    end
  end

  always_comb begin
    busy_c = 1'b0;
    for (int k = 0; k < STAGES; k++) busy_c = busy_c | (ctrl_q[k] != 2'b00);
  end

`ifdef DOT_ACCUM_SAT_EN
  // Saturation events ride down the tree with their data and only count when a command commits.
  logic sat_q    [1:LANES-1];
  logic sat_d    [1:LANES-1];
  logic sat_node [1:NODES-1];
  logic sat_flag_q;

  always_comb begin
    for (int n = 1; n < LANES; n++) sat_node[n] = sat_q[n];
    for (int i = 0; i < LANES; i++) sat_node[LANES+i] = 1'b0;
  end

  always_comb begin
    for (int n = 1; n < LANES; n++)
      sat_d[n] = sat_node[2*n] | sat_node[2*n+1] | ovf_fn(node[2*n], node[2*n+1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 1; n < LANES; n++) sat_q[n] <= 1'b0;
      sat_flag_q <= 1'b0;
    end else if (!bus.stall) begin
      for (int n = 1; n < LANES; n++) sat_q[n] <= sat_d[n];
      case (ctrl_q[STAGES-1])
        2'b01:   sat_flag_q <= sat_flag_q | sat_q[1];
        2'b10:   sat_flag_q <= sat_flag_q | sat_q[1] | ovf_fn(acc_q, tree_q[1]);
        2'b11:   sat_flag_q <= 1'b0;
        default: sat_flag_q <= sat_flag_q;
      endcase
    end
  end

  assign bus.sat_flag = sat_flag_q;
`else
  assign bus.sat_flag = 1'b0;
`endif

  assign bus.dot_out   = acc_q;
  assign bus.dot_valid = vld_q;
  assign bus.busy      = busy_c;

endmodule

// File: doc/dot_accum.md
DOT_ACCUM -- requirements
Module: dot_accum

Interface
REQ-001 The block SHALL have parameter LANES, default 8, number of PE lanes (power of two, >= 2).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, lane product and result width (two's complement).
REQ-003 The block SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit, freezes the whole pipeline while high.
REQ-006 The block SHALL have port dot_ctrl, input, 2 bits, decoder command: 00 disable, 01 shift, 10 accumulate, 11 clear.
REQ-007 The block SHALL have port prod_in, input, LANES*DATA_WIDTH bits, PE lane products; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have port dot_out, output, DATA_WIDTH bits, accumulator value, written back when r_select=1.
REQ-009 The block SHALL have port dot_valid, output, 1 bit, one-cycle pulse when the accumulator has just been updated.
REQ-010 The block SHALL have port busy, output, 1 bit, high while any pipeline stage holds a non-00 command.
REQ-011 The block SHALL have port sat_flag, output, 1 bit, sticky saturation indicator (see Configuration).

Function
REQ-012 The block SHALL reduce the LANES products with a pipelined binary adder tree of log2(LANES) register stages, each stage summing adjacent pairs.
REQ-013 The block SHALL carry dot_ctrl through the tree alongside its data, one ctrl register per stage.
REQ-014 At the accumulate stage, 01 (shift) SHALL load acc <= tree_sum, starting a new dot product.
REQ-015 At the accumulate stage, 10 (accumulate) SHALL update acc <= acc + tree_sum.
REQ-016 At the accumulate stage, 11 (clear) SHALL set acc <= 0 and ignore tree_sum.
REQ-017 At the accumulate stage, 00 SHALL hold acc and keep dot_valid low.
REQ-018 dot_valid SHALL be high for exactly the one cycle following each non-00 command's acc update; dot_out SHALL always equal acc.
REQ-019 Latency SHALL be log2(LANES)+1 cycles from dot_ctrl/prod_in sampling to the updated dot_out, with no stall.
REQ-020 Throughput SHALL be one command per cycle; back-to-back commands SHALL be applied in issue order with no bubbles.
REQ-021 While stall=1, every stage register, ctrl register, acc and sat_flag SHALL hold, dot_valid SHALL be 0, and inputs SHALL NOT be sampled.
REQ-022 Without the Configuration feature, all sums SHALL wrap modulo 2^DATA_WIDTH.
REQ-023 busy SHALL be the OR of the (ctrl != 00) flags of all tree stages.

Reset
REQ-024 When rst=1 at a clock edge, all stage data registers and acc SHALL become 0, all ctrl registers 00, dot_valid 0 and sat_flag 0.
REQ-025 rst SHALL take priority over stall.
REQ-026 Commands in flight at reset SHALL be discarded and SHALL produce no dot_valid pulse.

Configuration
REQ-027 With macro DOT_ACCUM_SAT_EN defined, every tree adder and the accumulate adder SHALL saturate to the signed DATA_WIDTH range, and sat_flag SHALL set on any saturation and clear only on a clear command or rst.
REQ-028 Without DOT_ACCUM_SAT_EN, arithmetic SHALL wrap per REQ-022 and sat_flag SHALL be tied to 0.

Verification (LANES=4, DATA_WIDTH=32, latency 3)
REQ-029 Reset, then shift with lanes {1,2,3,4} -> dot_out=10, with dot_valid high exactly 3 cycles after issue for one cycle.
REQ-030 Shift {1,1,1,1}, then accumulate {2,2,2,2} next cycle -> dot_out 4 and then 12 on consecutive cycles, with dot_valid high both cycles.
REQ-031 Accumulate to 12, then clear -> dot_out=0 with one dot_valid pulse, and busy low afterwards.
REQ-032 Shift {5,5,5,5} with stall high for 2 cycles mid-flight -> dot_out=20 arrives 5 cycles after issue with no extra dot_valid pulses.
REQ-033 Shift {0x7FFFFFFF,1,0,0} -> dot_out=0x80000000 and sat_flag=0 without the macro; dot_out=0x7FFFFFFF and sat_flag=1 with DOT_ACCUM_SAT_EN.
REQ-034 rst pulsed one cycle after a shift issue -> no dot_valid, dot_out=0, busy=0.
